// File: rtl/digit_scan_ctrl.sv
// Scan controller for a 4-digit one-hot nibble mux: a prescaled digit rotation with
// a blanking gap per slot, and a double-buffered display value applied at frame wrap.
module digit_scan_ctrl #(
    parameter int DIV   = 50000,
    parameter int BLANK = 4,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value,
    output logic [3:0]  sel,
    output logic [3:0]  d0,
    output logic [3:0]  d1,
    output logic [3:0]  d2,
    output logic [3:0]  d3,
    output logic        pending,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       idx;
    logic [1:0]       idx_nxt;
    logic             slot_end;
    logic             wrap;
    logic             blank_nxt;
    logic [3:0]       sel_nxt;
    logic [15:0]      shadow;

    always_comb begin
        slot_end = en && (cnt == CNT_LAST);
        wrap     = slot_end && (idx == 2'd3);
        cnt_nxt  = cnt;
        idx_nxt  = idx;
        if (en) begin
            if (slot_end) begin
                cnt_nxt = '0;
                idx_nxt = idx + 2'd1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // Blanking is decided on the next-state count so sel lines up with the slot it drives.
    generate
        if (BLANK == 0) begin : g_no_blank
            assign blank_nxt = 1'b0;
        end else begin : g_blank
            assign blank_nxt = (cnt_nxt < CNT_W'(BLANK));
        end
    endgenerate

    always_comb begin
        sel_nxt = 4'b0000;
        if (en && !blank_nxt) begin
            sel_nxt = 4'b0001 << idx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
            sel <= '0;
        end else begin
            cnt <= cnt_nxt;
            idx <= idx_nxt;
            sel <= sel_nxt;
        end
    end

    // A load coinciding with the wrap goes straight to the display so it is not held a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow     <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            d0         <= '0;
            d1         <= '0;
            d2         <= '0;
            d3         <= '0;
        end else begin
            frame_done <= 1'b0;
            if (load) begin
                shadow <= value;
            end
            if (wrap && load) begin
                d0         <= value[3:0];
                d1         <= value[7:4];
                d2         <= value[11:8];
                d3         <= value[15:12];
                pending    <= 1'b0;
                frame_done <= 1'b1;
            end else if (wrap && pending) begin
                d0         <= shadow[3:0];
                d1         <= shadow[7:4];
                d2         <= shadow[11:8];
                d3         <= shadow[15:12];
                pending    <= 1'b0;
                frame_done <= 1'b1;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with DIV=8, BLANK=2 (32-cycle frame).
module tb_digit_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  sel;
    logic [3:0]  d0;
    logic [3:0]  d1;
    logic [3:0]  d2;
    logic [3:0]  d3;
    logic        pending;
    logic        frame_done;

    int errors = 0;
    int checks = 0;
    int k = 0;  // enabled edges since reset: cnt = k%8, idx = (k/8)%4

    digit_scan_ctrl #(.DIV(8), .BLANK(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .value(value),
        .sel(sel), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .pending(pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        logic e;
        e = en && !rst;
        @(posedge clk);
        #1;
        if (e) k++;
    endtask

    task automatic advance_to(input int t);
        for (int n = 0; n < 40 && (k % 32) != t; n++) tick();
    endtask

    function automatic logic [3:0] exp_sel(input int kk);
        logic [3:0] one;
        one = 4'b0001;
        if ((kk % 8) < 2) return 4'b0000;
        return one << ((kk / 8) % 4);
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; value = 16'h0000;
        tick(); tick();
        checks++;
        if ({sel, d3, d2, d1, d0, pending, frame_done} !== 22'd0) begin
            errors++;
            $display("FAIL reset_state: got sel=%b d=%h%h%h%h pend=%b fd=%b, want all 0",
                     sel, d3, d2, d1, d0, pending, frame_done);
        end
        rst = 1'b0;
        k = 0;
        tick();
        checks++;
        if (sel !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset: sel=%b want 0000", sel);
        end
    endtask

    task automatic test_scan();
        en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            checks++;
            if (sel !== exp_sel(k)) begin
                errors++;
                $display("FAIL scan_sel k=%0d: sel=%b want %b", k, sel, exp_sel(k));
            end
            checks++;
            if ({d3, d2, d1, d0, frame_done} !== 17'd0) begin
                errors++;
                $display("FAIL scan_quiet k=%0d: d=%h%h%h%h fd=%b want 0", k, d3, d2, d1, d0, frame_done);
            end
        end
    endtask

    task automatic test_load();
        advance_to(11);
        value = 16'hA5C3; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (pending !== 1'b1 || {d3, d2, d1, d0} !== 16'h0000 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL load_pending: pend=%b d=%h%h%h%h fd=%b want 1/0000/0", pending, d3, d2, d1, d0, frame_done);
        end
        for (int n = 0; n < 32 && (k % 32) != 31; n++) begin
            tick();
            checks++;
            if (frame_done !== 1'b0 || {d3, d2, d1, d0} !== 16'h0000 || pending !== 1'b1) begin
                errors++;
                $display("FAIL load_hold k=%0d: fd=%b d=%h%h%h%h pend=%b", k, frame_done, d3, d2, d1, d0, pending);
            end
        end
        tick();
        checks++;
        if (d0 !== 4'h3 || d1 !== 4'hC || d2 !== 4'h5 || d3 !== 4'hA) begin
            errors++;
            $display("FAIL load_apply: d0..d3=%h %h %h %h want 3 C 5 A", d0, d1, d2, d3);
        end
        checks++;
        if (frame_done !== 1'b1 || pending !== 1'b0) begin
            errors++;
            $display("FAIL load_pulse: fd=%b pend=%b want 1/0", frame_done, pending);
        end
        tick();
        checks++;
        if (frame_done !== 1'b0 || {d3, d2, d1, d0} !== 16'hA5C3) begin
            errors++;
            $display("FAIL load_after: fd=%b d=%h%h%h%h want 0/A5C3", frame_done, d3, d2, d1, d0);
        end
    endtask

    task automatic test_last_wins();
        int pulses;
        value = 16'h1111; load = 1'b1;
        tick();
        load = 1'b0;
        tick(); tick(); tick();
        value = 16'h2222; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (pending !== 1'b1 || {d3, d2, d1, d0} !== 16'hA5C3) begin
            errors++;
            $display("FAIL last_wins_pending: pend=%b d=%h%h%h%h want 1/A5C3", pending, d3, d2, d1, d0);
        end
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (frame_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL last_wins_pulses: got %0d pulses want 1", pulses);
        end
        checks++;
        if ({d3, d2, d1, d0} !== 16'h2222 || pending !== 1'b0) begin
            errors++;
            $display("FAIL last_wins_value: d=%h%h%h%h pend=%b want 2222/0", d3, d2, d1, d0, pending);
        end
    endtask

    task automatic test_boundary_load();
        advance_to(31);
        value = 16'hBEEF; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (d0 !== 4'hF || d1 !== 4'hE || d2 !== 4'hE || d3 !== 4'hB) begin
            errors++;
            $display("FAIL boundary_value: d0..d3=%h %h %h %h want F E E B", d0, d1, d2, d3);
        end
        checks++;
        if (pending !== 1'b0 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL boundary_flags: pend=%b fd=%b want 0/1", pending, frame_done);
        end
        tick();
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL boundary_single: fd=%b want 0", frame_done);
        end
    endtask

    task automatic test_enable_pause();
        advance_to(21);
        checks++;
        if (sel !== 4'b0100) begin
            errors++;
            $display("FAIL pause_before: sel=%b want 0100", sel);
        end
        en = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            checks++;
            if (sel !== 4'b0000 || frame_done !== 1'b0 || {d3, d2, d1, d0} !== 16'hBEEF) begin
                errors++;
                $display("FAIL pause_blank n=%0d: sel=%b fd=%b d=%h%h%h%h want 0000/0/BEEF",
                         n, sel, frame_done, d3, d2, d1, d0);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if (sel !== 4'b0100) begin
            errors++;
            $display("FAIL resume_1: sel=%b want 0100", sel);
        end
        tick();
        checks++;
        if (sel !== 4'b0100) begin
            errors++;
            $display("FAIL resume_2: sel=%b want 0100", sel);
        end
        tick();
        checks++;
        if (sel !== 4'b0000) begin
            errors++;
            $display("FAIL resume_slot_end: sel=%b want 0000", sel);
        end
        tick(); tick();
        checks++;
        if (sel !== 4'b1000) begin
            errors++;
            $display("FAIL resume_next_digit: sel=%b want 1000", sel);
        end
    endtask

    task automatic test_reset_discard();
        value = 16'h1234; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL discard_pending: pend=%b want 1", pending);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        k = 0;
        checks++;
        if ({sel, d3, d2, d1, d0, pending, frame_done} !== 22'd0) begin
            errors++;
            $display("FAIL discard_reset: sel=%b d=%h%h%h%h pend=%b fd=%b want all 0",
                     sel, d3, d2, d1, d0, pending, frame_done);
        end
        for (int n = 0; n < 64; n++) begin
            tick();
            checks++;
            if (frame_done !== 1'b0 || pending !== 1'b0 || {d3, d2, d1, d0} !== 16'h0000 || sel !== exp_sel(k)) begin
                errors++;
                $display("FAIL discard_quiet k=%0d: fd=%b pend=%b d=%h%h%h%h sel=%b want 0/0/0000/%b",
                         k, frame_done, pending, d3, d2, d1, d0, sel, exp_sel(k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_last_wins();
        test_boundary_load();
        test_enable_pause();
        test_reset_discard();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
